// File: rtl/morse_symbol_tx.sv
// Morse symbol transmitter.
// Symbols come in over a valid/ready handshake, wait in a small FIFO, and go out
// on a single serial line as timed mark (high) and gap (low) intervals.
//
// Parameters:
//   UNIT  - clock cycles per Morse time unit (>= 1)
//   DEPTH - symbol FIFO entries (power of 2, >= 2)
// Ports:
//   clk_i        - clock, rising edge
//   rst_i        - asynchronous active-high reset
//   sym_valid_i  - a symbol is offered on sym_i
//   sym_i        - 00 dot, 11 dash, 10 space (letter gap), 01 reserved
//   sym_ready_o  - FIFO can accept a symbol
//   data_out_o   - registered serial Morse line
//   busy_o       - FIFO non-empty or transmitter active
//   err_o        - one-cycle pulse when a reserved code is dequeued
//   level_o      - current FIFO occupancy
module morse_symbol_tx #(
    parameter int unsigned UNIT  = 2,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     sym_valid_i,
    input  logic [1:0]               sym_i,
    output logic                     sym_ready_o,
    output logic                     data_out_o,
    output logic                     busy_o,
    output logic                     err_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned LvlW = $clog2(DEPTH) + 1;
    localparam int unsigned CntW = $clog2(3 * UNIT);

    // Counter loads are "remaining cycles minus one".
    localparam logic [CntW-1:0] UnitCnt  = CntW'(UNIT - 1);
    localparam logic [CntW-1:0] TripleCnt = CntW'(3 * UNIT - 1);

    localparam logic [1:0] SymDot   = 2'b00;
    localparam logic [1:0] SymDash  = 2'b11;
    localparam logic [1:0] SymSpace = 2'b10;

    typedef enum logic [1:0] {
        StIdle,
        StMark,
        StGap
    } state_e;

    logic [1:0]      mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [LvlW-1:0] level_q;
    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic            data_out_q;
    logic            err_q;

    logic       full;
    logic       empty;
    logic       push;
    logic       pop;
    logic [1:0] head;

    assign full  = (level_q == LvlW'(DEPTH));
    assign empty = (level_q == '0);
    // Full blocks a push even when a pop happens on the same edge.
    assign push  = sym_valid_i && !full;
    // Pops only at a symbol boundary; an empty FIFO is checked before this
    // edge's push, so there is no same-edge bypass.
    assign pop   = !empty && ((state_q == StIdle) || ((state_q == StGap) && (cnt_q == '0)));
    assign head  = mem_q[rd_ptr_q];

    assign sym_ready_o = !full && !rst_i;
    assign data_out_o  = data_out_q;
    assign err_o       = err_q;
    assign level_o     = level_q;
    assign busy_o      = !empty || (state_q != StIdle);

    // Storage needs no reset: pointers and level define what is valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= sym_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + LvlW'(1);
                2'b01:   level_q <= level_q - LvlW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            data_out_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (pop) begin
                case (head)
                    SymDot: begin
                        state_q    <= StMark;
                        cnt_q      <= UnitCnt;
                        data_out_q <= 1'b1;
                    end
                    SymDash: begin
                        state_q    <= StMark;
                        cnt_q      <= TripleCnt;
                        data_out_q <= 1'b1;
                    end
                    SymSpace: begin
                        state_q    <= StGap;
                        cnt_q      <= TripleCnt;
                        data_out_q <= 1'b0;
                    end
                    default: begin
                        // Reserved code: flag it and consume no line time.
                        state_q    <= StIdle;
                        cnt_q      <= '0;
                        data_out_q <= 1'b0;
                        err_q      <= 1'b1;
                    end
                endcase
            end else begin
                case (state_q)
                    StMark: begin
                        if (cnt_q == '0) begin
                            // Every mark is followed by a one-unit element gap.
                            state_q    <= StGap;
                            cnt_q      <= UnitCnt;
                            data_out_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q - CntW'(1);
                        end
                    end
                    StGap: begin
                        if (cnt_q != '0) begin
                            cnt_q <= cnt_q - CntW'(1);
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_morse_symbol_tx.sv
// Directed bench for morse_symbol_tx with UNIT=2, DEPTH=4.
// Inputs change 1 time unit after each rising edge; outputs are sampled there too,
// so "after edge N" below means the value observed right after rising edge N.
module tb_morse_symbol_tx;

    localparam int unsigned UNIT  = 2;
    localparam int unsigned DEPTH = 4;

    logic       clk_i       = 1'b0;
    logic       rst_i       = 1'b1;
    logic       sym_valid_i = 1'b0;
    logic [1:0] sym_i       = 2'b00;
    logic       sym_ready_o;
    logic       data_out_o;
    logic       busy_o;
    logic       err_o;
    logic [2:0] level_o;

    int checks = 0;
    int errors = 0;

    morse_symbol_tx #(
        .UNIT  (UNIT),
        .DEPTH (DEPTH)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .sym_valid_i (sym_valid_i),
        .sym_i       (sym_i),
        .sym_ready_o (sym_ready_o),
        .data_out_o  (data_out_o),
        .busy_o      (busy_o),
        .err_o       (err_o),
        .level_o     (level_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if ({data_out_o, busy_o, err_o, sym_ready_o} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d: got data/busy/err/ready=%b expected 0000",
                         c, {data_out_o, busy_o, err_o, sym_ready_o});
            end
            checks++;
            if (level_o !== 3'd0) begin
                errors++;
                $display("FAIL reset_level cycle %0d: got %0d expected 0", c, level_o);
            end
        end
        rst_i = 1'b0;
        #1;
        checks++;
        if (sym_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b expected 1", sym_ready_o);
        end
    endtask

    task automatic test_single_dot();
        logic exp_d;
        logic exp_b;
        sym_i       = 2'b00;
        sym_valid_i = 1'b1;
        tick();  // edge 1
        sym_valid_i = 1'b0;
        checks++;
        if (level_o !== 3'd1 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL dot_accept: got level=%0d busy=%b expected level=1 busy=1",
                     level_o, busy_o);
        end
        for (int e = 2; e <= 6; e++) begin
            tick();
            exp_d = (e == 2 || e == 3);
            exp_b = (e < 6);
            checks++;
            if (data_out_o !== exp_d) begin
                errors++;
                $display("FAIL dot_line edge %0d: got %b expected %b", e, data_out_o, exp_d);
            end
            checks++;
            if (busy_o !== exp_b) begin
                errors++;
                $display("FAIL dot_busy edge %0d: got %b expected %b", e, busy_o, exp_b);
            end
        end
    endtask

    task automatic test_backpressure();
        logic exp_r;
        logic exp_d;
        int   n;
        sym_i       = 2'b11;
        sym_valid_i = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            exp_r = (e <= 5);
            checks++;
            if (sym_ready_o !== exp_r) begin
                errors++;
                $display("FAIL bp_ready before edge %0d: got %b expected %b",
                         e, sym_ready_o, exp_r);
            end
            tick();
            exp_d = (e >= 2 && e <= 7) || (e == 10);
            checks++;
            if (data_out_o !== exp_d) begin
                errors++;
                $display("FAIL bp_line edge %0d: got %b expected %b", e, data_out_o, exp_d);
            end
            if (e == 5) begin
                checks++;
                if (level_o !== 3'd4 || sym_ready_o !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_full: got level=%0d ready=%b expected level=4 ready=0",
                             level_o, sym_ready_o);
                end
            end
        end
        sym_valid_i = 1'b0;
        checks++;
        if (sym_ready_o !== 1'b1 || level_o !== 3'd3) begin
            errors++;
            $display("FAIL bp_second_pop: got ready=%b level=%0d expected ready=1 level=3",
                     sym_ready_o, level_o);
        end
        n = 0;
        while (busy_o && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (busy_o !== 1'b0 || level_o !== 3'd0) begin
            errors++;
            $display("FAIL bp_drain: got busy=%b level=%0d after %0d cycles expected 0 0",
                     busy_o, level_o, n);
        end
    endtask

    task automatic test_sos();
        logic [1:0] tbl [11];
        int         exp_hi [9];
        int         exp_lo [8];
        int         hi [12];
        int         lo [12];
        int         nh;
        int         nl;
        int         idx;
        int         cyc;
        int         first_rise;
        int         fall;
        int         run;
        logic       prev;
        logic       acc;
        tbl    = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b11, 2'b11, 2'b11, 2'b10,
                   2'b00, 2'b00, 2'b00};
        exp_hi = '{2, 2, 2, 6, 6, 6, 2, 2, 2};
        exp_lo = '{2, 2, 8, 2, 2, 8, 2, 2};
        nh = 0; nl = 0; idx = 0; cyc = 0; first_rise = -1; fall = -1; run = 0; prev = 1'b0;
        while (cyc < 200) begin
            sym_valid_i = (idx < 11);
            sym_i       = (idx < 11) ? tbl[idx] : 2'b00;
            acc         = sym_valid_i && sym_ready_o;
            tick();
            cyc++;
            if (acc) idx++;
            if (!busy_o) begin
                fall = cyc;
                break;
            end
            if (first_rise < 0) begin
                if (data_out_o) begin
                    first_rise = cyc;
                    prev       = 1'b1;
                    run        = 1;
                end
            end else if (data_out_o == prev) begin
                run++;
            end else begin
                if (prev && nh < 12) begin
                    hi[nh] = run;
                    nh++;
                end else if (!prev && nl < 12) begin
                    lo[nl] = run;
                    nl++;
                end
                prev = data_out_o;
                run  = 1;
            end
        end
        sym_valid_i = 1'b0;
        checks++;
        if (fall < 0 || first_rise < 0 || (fall - first_rise) != 60) begin
            errors++;
            $display("FAIL sos_span: got first_rise=%0d busy_fall=%0d expected span 60",
                     first_rise, fall);
        end
        checks++;
        if (idx != 11) begin
            errors++;
            $display("FAIL sos_accepted: got %0d expected 11", idx);
        end
        checks++;
        if (nh != 9 || nl != 8) begin
            errors++;
            $display("FAIL sos_pulse_count: got %0d highs %0d lows expected 9 and 8", nh, nl);
        end
        for (int i = 0; i < 9; i++) begin
            if (i < nh) begin
                checks++;
                if (hi[i] != exp_hi[i]) begin
                    errors++;
                    $display("FAIL sos_high %0d: got %0d expected %0d", i, hi[i], exp_hi[i]);
                end
            end
        end
        for (int i = 0; i < 8; i++) begin
            if (i < nl) begin
                checks++;
                if (lo[i] != exp_lo[i]) begin
                    errors++;
                    $display("FAIL sos_low %0d: got %0d expected %0d", i, lo[i], exp_lo[i]);
                end
            end
        end
    endtask

    task automatic test_reserved();
        logic exp_d;
        logic exp_e;
        for (int e = 1; e <= 12; e++) begin
            sym_valid_i = (e <= 3);
            sym_i       = (e == 2) ? 2'b01 : 2'b00;
            tick();
            sym_valid_i = 1'b0;
            exp_d = (e == 2 || e == 3 || e == 7 || e == 8);
            exp_e = (e == 6);
            checks++;
            if (data_out_o !== exp_d) begin
                errors++;
                $display("FAIL rsv_line edge %0d: got %b expected %b", e, data_out_o, exp_d);
            end
            checks++;
            if (err_o !== exp_e) begin
                errors++;
                $display("FAIL rsv_err edge %0d: got %b expected %b", e, err_o, exp_e);
            end
        end
        checks++;
        if (busy_o !== 1'b0 || level_o !== 3'd0) begin
            errors++;
            $display("FAIL rsv_idle: got busy=%b level=%0d expected 0 0", busy_o, level_o);
        end
    endtask

    task automatic test_reset_mid_dash();
        int highs;
        int busies;
        sym_i       = 2'b11;
        sym_valid_i = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            tick();
        end
        sym_valid_i = 1'b0;
        checks++;
        if (data_out_o !== 1'b1 || level_o !== 3'd3) begin
            errors++;
            $display("FAIL rmid_setup: got data=%b level=%0d expected 1 3", data_out_o, level_o);
        end
        #3;
        rst_i = 1'b1;
        #1;
        checks++;
        if (data_out_o !== 1'b0) begin
            errors++;
            $display("FAIL rmid_async_line: got %b expected 0", data_out_o);
        end
        checks++;
        if (level_o !== 3'd0 || busy_o !== 1'b0 || sym_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL rmid_state: got level=%0d busy=%b ready=%b expected 0 0 0",
                     level_o, busy_o, sym_ready_o);
        end
        tick();
        rst_i = 1'b0;
        #1;
        checks++;
        if (sym_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL rmid_release_ready: got %b expected 1", sym_ready_o);
        end
        highs  = 0;
        busies = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (data_out_o) highs++;
            if (busy_o) busies++;
        end
        checks++;
        if (highs != 0 || busies != 0) begin
            errors++;
            $display("FAIL rmid_quiet: got %0d high and %0d busy cycles expected 0 0",
                     highs, busies);
        end
        sym_i       = 2'b00;
        sym_valid_i = 1'b1;
        tick();
        sym_valid_i = 1'b0;
        tick();
        checks++;
        if (data_out_o !== 1'b1) begin
            errors++;
            $display("FAIL rmid_restart: got %b expected 1", data_out_o);
        end
    endtask

    initial begin
        test_reset();
        test_single_dot();
        test_backpressure();
        test_sos();
        test_reserved();
        test_reset_mid_dash();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/morse_symbol_tx.md
# morse_symbol_tx

Morse symbol transmitter: the transmit end of the dot/dash/space symbol interface that `dash_dot` produces on the receive side. It accepts 2-bit symbol codes through a valid/ready handshake into a small FIFO. It serializes each symbol onto a single-bit line `data_out` as timed mark (high) and gap (low) intervals. It sits in front of a serial line or loopback and feeds `dash_dot`/`sos_detector` in system benches.

## Interface
- `UNIT`, 2: clock cycles per Morse time unit; legal range ≥1.
- `DEPTH`, 4: symbol FIFO entries; power of 2, ≥2.

- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `sym_valid`  in  1  a symbol is offered on `sym`.
- `sym`  in  2  symbol code: 2'b00 dot, 2'b11 dash, 2'b10 space (letter gap), 2'b01 reserved.
- `sym_ready`  out  1  FIFO can accept; transfer occurs on an edge where `sym_valid && sym_ready`.
- `data_out`  out  1  serial Morse line, registered.
- `busy`  out  1  FIFO non-empty or FSM not in IDLE.
- `err`  out  1  one-cycle pulse when a reserved code is dequeued.
- `level`  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- **FIFO**
  - `sym_ready = !full && !rst`.
  - A push is blocked when full, even if a pop occurs on the same edge.
  - No bypass: a symbol pushed into an empty FIFO is not popped on the same edge.
  - Read and write pointers wrap modulo DEPTH.
- **FSM states:** IDLE, MARK, GAP. Down-counter `cnt` holds the remaining cycles minus 1.
- **Pop rule.** Pops occur only in IDLE, or in GAP when `cnt==0`, and only if the FIFO is non-empty. The popped code selects the next state:
  - dot: MARK, `cnt=UNIT-1`.
  - dash: MARK, `cnt=3*UNIT-1`.
  - space: GAP, `cnt=3*UNIT-1`.
  - reserved: IDLE, `err=1` for one cycle; no line time is consumed.
- **Empty FIFO.** In GAP with `cnt==0` and an empty FIFO, go to IDLE. In IDLE with an empty FIFO, remain in IDLE.
- **MARK.** When `cnt==0`, go to GAP with `cnt=UNIT-1` (the inter-element gap). Otherwise decrement `cnt`.
- **GAP.** When `cnt!=0`, decrement `cnt`.
- **Outputs.** `data_out` is 1 exactly while the state is MARK. Symbols chain back-to-back with no idle bubble.
- **Line time per symbol:**
  - dot: UNIT high + UNIT low.
  - dash: 3·UNIT high + UNIT low.
  - space: 3·UNIT low.
- **Reset.** `rst` high clears the FIFO, pointers and `cnt`, and forces the FSM to IDLE, asynchronously and mid-symbol included.
  - Output reset values: `data_out=0`, `busy=0`, `err=0`, `level=0`, `sym_ready=0`.
  - After release, `sym_ready=1` at once.

## Timing
- With an idle block, a symbol accepted at edge N is popped at edge N+1. `data_out` rises after edge N+1 for a dot or dash.
- `busy` is high from edge N through the last GAP cycle. It falls on the edge where the FSM enters IDLE with the FIFO empty.
- `level` updates on each edge: +1 on push, −1 on pop, unchanged on simultaneous push and pop.
- `err` is asserted for the single cycle following the pop edge of a reserved code. The following symbol is popped one edge later, from IDLE.

## Test plan
- **Reset.** Hold `rst` high for 3 cycles.
  - During reset: `data_out=0`, `busy=0`, `err=0`, `level=0`, `sym_ready=0`.
  - After release: `sym_ready=1`.
- **Single dot (UNIT=2).** Push 2'b00 at edge 1.
  - `data_out` is high after edges 2–3 and low after edges 4–5.
  - `busy` falls at edge 6, with the FSM in IDLE.
- **Backpressure (DEPTH=4).** Hold `sym_valid=1` with dashes from edge 1.
  - Acceptances occur at edges 1–5; `level=4` and `sym_ready=0` after edge 5.
  - The first dash is high for 6 cycles (edges 2–7) and low for 2.
  - The next pop occurs at edge 10, so `sym_ready=1` after edge 10.
- **SOS stream.** Feed dot ×3, space, dash ×3, space, dot ×3 while respecting `sym_ready`.
  - `busy` stays high continuously for 60 cycles with no idle cycle between symbols.
  - High-pulse widths are 2,2,2,6,6,6,2,2,2.
  - Low runs between pulses are 2, or 8 at each space (2 + 6).
- **Reserved code.** Push dot, 2'b01, dot.
  - `err` pulses once, in the cycle after the first dot's gap ends.
  - The second dot starts one cycle later, with no mark for the reserved code.
- **Reset mid-dash.** Assert `rst` asynchronously mid-MARK with 3 entries queued.
  - `data_out` falls without waiting for a clock edge.
  - `level=0` and `busy=0`.
  - After release, nothing is transmitted until new symbols are pushed.
